// File: rtl/norm_sched_pkg.sv
// Shared types and width helpers for the normalize scheduler.
// Optional stall counter in norm_sched is enabled by NORM_SCHED_STALL_CNT_EN.
package norm_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        HOLD  = 2'd2
    } state_e;

    localparam int MAX_WIDTH = 64;
    localparam int MAX_REQ   = 16;
    localparam int MAX_CNT_W = $clog2(MAX_WIDTH) + 1;
    localparam int MAX_ID_W  = $clog2(MAX_REQ);

    // Count width must be able to hold the value WIDTH itself (all-zero operand).
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

    function automatic int id_width(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

    typedef struct packed {
        logic [MAX_ID_W-1:0]  id;
        logic [MAX_WIDTH-1:0] data;
        logic [MAX_CNT_W-1:0] shift;
        logic                 zero;
    } resp_t;

endpackage

// File: rtl/norm_rr_arbiter.sv
// Round-robin grant over the requester lanes; the pointer moves past the
// granted lane only when the grant is actually taken (advance).
module norm_rr_arbiter
    import norm_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = id_width(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant_onehot,
    output logic [ID_W-1:0]    grant_idx,
    output logic               grant_any
);

    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] cand;

    // Search upward from rr_ptr, wrapping, and keep the first requesting lane.
    always_comb begin
        grant_onehot = '0;
        grant_idx    = '0;
        grant_any    = 1'b0;
        cand         = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = ID_W'((int'(rr_ptr) + i) % NUM_REQ);
            if (!grant_any && req[cand]) begin
                grant_any          = 1'b1;
                grant_idx          = cand;
                grant_onehot[cand] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (advance) begin
            rr_ptr <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/norm_sched.sv
// Shared leading-zero-count and normalize-shift unit arbitrated between lanes.
// Define NORM_SCHED_STALL_CNT_EN to add the 32-bit stall_cnt output.
module norm_sched
    import norm_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 64,
    parameter int ID_W    = id_width(NUM_REQ),
    parameter int CNT_W   = cnt_width(WIDTH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [ID_W-1:0]          resp_id,
    output logic [WIDTH-1:0]         resp_data,
    output logic [CNT_W-1:0]         resp_shift,
    output logic                     resp_zero
`ifdef NORM_SCHED_STALL_CNT_EN
    ,
    output logic [31:0]              stall_cnt
`endif
);

    state_e               state_q;
    state_e               state_d;
    logic [NUM_REQ-1:0]   grant_onehot;
    logic [ID_W-1:0]      grant_idx;
    logic                 grant_any;
    logic                 accept;
    logic [WIDTH-1:0]     op_q;
    logic [ID_W-1:0]      id_q;
    logic [CNT_W-1:0]     lz_cnt;

    norm_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req_valid),
        .advance      (accept),
        .grant_onehot (grant_onehot),
        .grant_idx    (grant_idx),
        .grant_any    (grant_any)
    );

    // Grants are only offered in IDLE, so a response waiting in HOLD blocks new work.
    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        accept    = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = grant_onehot;
                accept    = grant_any;
                if (grant_any) begin
                    state_d = COUNT;
                end
            end
            COUNT: state_d = HOLD;
            HOLD: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Later (higher) set bits overwrite earlier ones, leaving the count above the top 1.
    always_comb begin
        lz_cnt = CNT_W'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (op_q[i]) begin
                lz_cnt = CNT_W'(WIDTH - 1 - i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q       <= '0;
            id_q       <= '0;
            resp_valid <= 1'b0;
            resp_id    <= '0;
            resp_data  <= '0;
            resp_shift <= '0;
            resp_zero  <= 1'b0;
        end else begin
            if (accept) begin
                op_q <= req_data[int'(grant_idx) * WIDTH +: WIDTH];
                id_q <= grant_idx;
            end
            if (state_q == COUNT) begin
                resp_valid <= 1'b1;
                resp_id    <= id_q;
                resp_data  <= op_q << lz_cnt;
                resp_shift <= lz_cnt;
                resp_zero  <= (op_q == '0);
            end else if (state_q == HOLD && resp_ready) begin
                resp_valid <= 1'b0;
            end
        end
    end

`ifdef NORM_SCHED_STALL_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (state_q == HOLD && !resp_ready && stall_cnt != 32'hFFFF_FFFF) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_norm_sched.sv
// Scoreboard bench for norm_sched: a reference model predicts grants and responses,
// a forked monitor compares every cycle; NORM_SCHED_STALL_CNT_EN also checks stall_cnt.
module tb_norm_sched;
    import norm_sched_pkg::*;

    localparam int NR = 4;
    localparam int W  = 64;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NR-1:0]     req_valid;
    logic [NR*W-1:0]   req_data;
    logic [NR-1:0]     req_ready;
    logic              resp_valid;
    logic              resp_ready;
    logic [1:0]        resp_id;
    logic [W-1:0]      resp_data;
    logic [6:0]        resp_shift;
    logic              resp_zero;
`ifdef NORM_SCHED_STALL_CNT_EN
    logic [31:0]       stall_cnt;
`endif

    int          pass_cnt = 0;
    int          total_cnt = 0;
    bit          in_flight = 0;
    int          age = 0;
    int          rr = 0;
    int          cycle = 0;
    logic [31:0] model_stall = 0;
    bit [NR-1:0] acc_flag = '0;
    bit          keep_all = 0;
    resp_t       sb_q[$];
    int          grant_log[$];
    int          hs_cycle[$];

    always #5 clk = ~clk;

    norm_sched #(.NUM_REQ(NR), .WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_data  (resp_data),
        .resp_shift (resp_shift),
        .resp_zero  (resp_zero)
`ifdef NORM_SCHED_STALL_CNT_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("[TB] FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Normalization from the arithmetic definition: shift = 63 - floor(log2(x)).
    function automatic resp_t model_resp(input int lane, input logic [63:0] x);
        resp_t r;
        int    msb;
        r    = '0;
        r.id = 4'(lane);
        if (x == 64'd0) begin
            r.shift = 7'd64;
            r.data  = 64'd0;
            r.zero  = 1'b1;
        end else begin
            msb     = $clog2({1'b0, x} + 65'd1) - 1;
            r.shift = 7'(63 - msb);
            r.data  = x << (63 - msb);
            r.zero  = 1'b0;
        end
        return r;
    endfunction

    function automatic logic [63:0] rand_operand();
        logic [63:0] r;
        r = {$urandom, $urandom};
        case ($urandom_range(0, 4))
            0: return 64'd0;
            1: return r | 64'h8000_0000_0000_0000;
            2: return 64'd1 << $urandom_range(0, 63);
            3: return r >> $urandom_range(0, 63);
            default: return r;
        endcase
    endfunction

    function automatic int logAt(input int k);
        return (k < grant_log.size()) ? grant_log[k] : -1;
    endfunction

    function automatic int hsAt(input int k);
        return (k < hs_cycle.size()) ? hs_cycle[k] : -100;
    endfunction

    task automatic setLane(input int i, input logic [63:0] d);
        req_valid[i]         = 1'b1;
        req_data[i*W +: W]   = d;
    endtask

    // One cycle of requester behaviour: retire (or re-arm) lanes accepted last edge.
    task automatic applyStimulus();
        @(posedge clk);
        #2;
        for (int i = 0; i < NR; i++) begin
            if (acc_flag[i]) begin
                acc_flag[i] = 1'b0;
                if (keep_all) setLane(i, rand_operand());
                else req_valid[i] = 1'b0;
            end
        end
    endtask

    task automatic waitIdle();
        bit idle;
        idle = 0;
        for (int n = 0; n < 80 && !idle; n++) begin
            applyStimulus();
            idle = !in_flight && (req_valid == '0) && (sb_q.size() == 0);
        end
        if (!idle) checkOutput("idle_timeout", 64'd0, 64'd1);
    endtask

    task automatic waitResp(output bit ok);
        ok = 0;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge clk);
            if (resp_valid) ok = 1;
            else applyStimulus();
        end
        if (!ok) checkOutput("resp_timeout", 64'd0, 64'd1);
    endtask

    task automatic checkResp(input string name, input int id, input logic [63:0] data,
                             input int shift, input bit zero);
        checkOutput({name, "_valid"}, 64'(resp_valid), 64'd1);
        checkOutput({name, "_id"},    64'(resp_id),    64'(id));
        checkOutput({name, "_data"},  resp_data,       data);
        checkOutput({name, "_shift"}, 64'(resp_shift), 64'(shift));
        checkOutput({name, "_zero"},  64'(resp_zero),  64'(zero));
    endtask

    // Reference model and scoreboard, evaluated once per cycle on the falling edge.
    task automatic monitor();
        logic [NR-1:0] exp_rdy;
        bit            found;
        bit            exp_valid;
        int            g;
        int            lane;
        resp_t         exp;
        forever begin
            @(negedge clk);
            cycle++;
            if (!rst_n) begin
                sb_q.delete();
                in_flight   = 0;
                age         = 0;
                rr          = 0;
                model_stall = 0;
                acc_flag    = '0;
            end else begin
                if (in_flight) age++;
                exp_rdy = '0;
                found   = 0;
                g       = 0;
                if (!in_flight) begin
                    for (int k = 0; k < NR; k++) begin
                        lane = (rr + k) % NR;
                        if (!found && req_valid[lane]) begin
                            found        = 1;
                            g            = lane;
                            exp_rdy[lane] = 1'b1;
                        end
                    end
                end
                checkOutput("req_ready", 64'(req_ready), 64'(exp_rdy));
                exp_valid = in_flight && (age >= 2);
                checkOutput("resp_valid", 64'(resp_valid), 64'(exp_valid));
                if (resp_valid) begin
                    if (sb_q.size() == 0) begin
                        checkOutput("resp_unexpected", 64'd1, 64'd0);
                    end else begin
                        exp = sb_q[0];
                        checkOutput("sb_id",    64'(resp_id),    64'(exp.id));
                        checkOutput("sb_data",  resp_data,       exp.data);
                        checkOutput("sb_shift", 64'(resp_shift), 64'(exp.shift));
                        checkOutput("sb_zero",  64'(resp_zero),  64'(exp.zero));
                    end
                end
`ifdef NORM_SCHED_STALL_CNT_EN
                checkOutput("stall_cnt", 64'(stall_cnt), 64'(model_stall));
                if (exp_valid && !resp_ready && model_stall != 32'hFFFF_FFFF) model_stall++;
`endif
                if (exp_valid && resp_ready) begin
                    if (sb_q.size() > 0) void'(sb_q.pop_front());
                    in_flight = 0;
                    hs_cycle.push_back(cycle);
                end
                if (found) begin
                    sb_q.push_back(model_resp(g, req_data[g*W +: W]));
                    grant_log.push_back(g);
                    rr          = (g + 1) % NR;
                    in_flight   = 1;
                    age         = 0;
                    acc_flag[g] = 1'b1;
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout");
        $fatal(1, "[TB] simulation time limit");
    end

    initial begin
        int  s;
        int  h;
        bit  ok;
        int  exp_order[5];
        exp_order = '{0, 1, 2, 3, 0};
        rst_n      = 1'b0;
        req_valid  = '0;
        req_data   = '0;
        resp_ready = 1'b0;
        fork
            monitor();
        join_none

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_req_ready",  64'(req_ready),  64'd0);
        checkOutput("rst_resp_valid", 64'(resp_valid), 64'd0);
        checkOutput("rst_resp_id",    64'(resp_id),    64'd0);
        checkOutput("rst_resp_data",  resp_data,       64'd0);
        checkOutput("rst_resp_shift", 64'(resp_shift), 64'd0);
        checkOutput("rst_resp_zero",  64'(resp_zero),  64'd0);
`ifdef NORM_SCHED_STALL_CNT_EN
        checkOutput("rst_stall_cnt",  64'(stall_cnt),  64'd0);
`endif
        @(posedge clk);
        #2;
        rst_n      = 1'b1;
        resp_ready = 1'b1;

        // All lanes valid back to back: strict rotation and one result per 3 cycles.
        s = grant_log.size();
        h = hs_cycle.size();
        keep_all = 1;
        for (int i = 0; i < NR; i++) setLane(i, rand_operand());
        for (int n = 0; n < 40 && grant_log.size() < s + 5; n++) applyStimulus();
        keep_all = 0;
        waitIdle();
        for (int k = 0; k < 5; k++) checkOutput("rr_order", 64'(logAt(s + k)), 64'(exp_order[k]));
        for (int k = 1; k < 5; k++) checkOutput("throughput", 64'(hsAt(h + k) - hsAt(h + k - 1)), 64'd3);

        // Lane 2 alone: ready in the request cycle, result two edges later.
        setLane(2, 64'h0000_0000_0001_0000);
        @(negedge clk);
        checkOutput("t1_req_ready", 64'(req_ready), 64'b0100);
        applyStimulus();
        applyStimulus();
        @(negedge clk);
        checkResp("t1", 2, 64'h8000_0000_0000_0000, 47, 1'b0);
        waitIdle();

        // All-zero operand.
        setLane(1, 64'd0);
        waitResp(ok);
        if (ok) checkResp("zero", 1, 64'd0, 64, 1'b1);
        waitIdle();

        // Held response with back-pressure; lane 3 must not be offered a grant meanwhile.
        resp_ready = 1'b0;
        setLane(0, 64'h8000_0000_0000_0001);
        waitResp(ok);
        if (ok) checkResp("hold_first", 0, 64'h8000_0000_0000_0001, 0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            applyStimulus();
            if (k == 0) setLane(3, 64'h0000_0000_0000_00FF);
            @(negedge clk);
            checkResp("hold", 0, 64'h8000_0000_0000_0001, 0, 1'b0);
            checkOutput("hold_no_ready", 64'(req_ready), 64'd0);
        end
`ifdef NORM_SCHED_STALL_CNT_EN
        checkOutput("hold_stall_cnt", 64'(stall_cnt), 64'd5);
`endif
        applyStimulus();
        resp_ready = 1'b1;
        waitIdle();

        // Move the pointer to 2, then lanes 3 and 1 together: 3 wins, then 1.
        setLane(1, rand_operand());
        waitIdle();
        s = grant_log.size();
        setLane(3, rand_operand());
        setLane(1, rand_operand());
        waitIdle();
        checkOutput("ptr2_first",  64'(logAt(s)),     64'd3);
        checkOutput("ptr2_second", 64'(logAt(s + 1)), 64'd1);

        // Reset while the operation is in COUNT: no response, pointer back to lane 0.
        s = grant_log.size();
        setLane(2, 64'h0000_0000_0000_0F00);
        applyStimulus();
        checkOutput("rst_mid_accepted", 64'(grant_log.size()), 64'(s + 1));
        rst_n     = 1'b0;
        req_valid = '0;
        @(negedge clk);
        checkOutput("rst_mid_valid", 64'(resp_valid), 64'd0);
        checkOutput("rst_mid_id",    64'(resp_id),    64'd0);
        applyStimulus();
        applyStimulus();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            applyStimulus();
            @(negedge clk);
            checkOutput("rst_after_valid", 64'(resp_valid), 64'd0);
        end
        applyStimulus();
        s = grant_log.size();
        for (int i = 0; i < NR; i++) setLane(i, rand_operand());
        waitIdle();
        checkOutput("rst_next_grant", 64'(logAt(s)), 64'd0);

        // Randomized traffic with random back-pressure and early valid drops.
        for (int n = 0; n < 600; n++) begin
            applyStimulus();
            resp_ready = ($urandom_range(0, 9) < 7);
            for (int i = 0; i < NR; i++) begin
                if (!req_valid[i] && $urandom_range(0, 3) == 0) setLane(i, rand_operand());
                else if (req_valid[i] && $urandom_range(0, 19) == 0) req_valid[i] = 1'b0;
            end
        end
        applyStimulus();
        resp_ready = 1'b1;
        waitIdle();
        checkOutput("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
